window_gen_nxn: RTL and testbench
=================================

Name: window_gen_nxn

Overview:
- Parametrised streaming KxK neighbourhood generator for the Canny chain (Sobel, non-max suppression, hysteresis).
- Successor to the fixed 3x3 shift-RAM window: line buffers are inferred internally rather than taken from a vendor IP, so it has no gated clocks.
- Adds odd kernel size K, valid/ready backpressure, frame framing (sof/eof) and window-centre coordinates.
- Emits only interior windows, one per accepted pixel once the window is complete.

Parameters:
- WIDTH, 640, pixels per line (>= KERNEL_SIZE).
- HEIGHT, 512, lines per frame (>= KERNEL_SIZE).
- DATA_WIDTH, 26, bits per pixel. NMS packing is {dir[1:0], grad[23:0]}, but the block is opaque to the payload.
- KERNEL_SIZE, 3, window size K; odd, 3..7.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_sof  in  1  qualifies in_valid; this pixel is (row 0, col 0).
- in_data  in  DATA_WIDTH  pixel, raster order.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_win  out  K*K*DATA_WIDTH  window. Element (r,c) sits at [((r*K)+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the oldest row, c=0 the leftmost column.
- out_row  out  $clog2(HEIGHT)  window-centre row.
- out_col  out  $clog2(WIDTH)  window-centre column.
- out_eof  out  1  qualifies out_valid: last window of the frame.

Behaviour:
- Reset values: out_valid=0, out_eof=0, out_win=0, out_row=0, out_col=0, counters=0, state=IDLE. Line-buffer contents are don't-care.
- Reset mid-frame aborts the frame; the next frame starts only on in_sof.
- Handshake:
  - in_ready = !out_valid || out_ready (single output register stage).
  - accept = in_valid && in_ready.
  - While out_valid && !out_ready, all out_* are held stable.
- State machine:
  - IDLE: accepted pixels without in_sof are dropped. An accept with in_sof goes to FILL.
  - FILL: row < K-1; no windows emitted. At end of line K-2, go to STREAM.
  - STREAM: emit windows. Accepting pixel (HEIGHT-1, WIDTH-1) goes to DONE.
  - DONE: behaves like IDLE.
  - An accept with in_sof in any state forces col=0, row=0, state FILL (for K=3 and above). The in-flight output is not cancelled.
- Counters (advance on accept only):
  - col wraps WIDTH-1 -> 0 and increments row.
  - row saturates in DONE.
- Line buffer:
  - K-1 lines of WIDTH entries, addressed by col.
  - On accept at col c, column vector = {lb[0][c] .. lb[K-2][c], in_data}.
  - Then lb[i][c] <= lb[i+1][c] and lb[K-2][c] <= in_data.
- Window registers:
  - Shift left by one column on every accept, including non-emitting positions.
  - The new column enters at c=K-1.
- Output timing:
  - Accepting pixel (R, C) with R >= K-1 and C >= K-1 sets out_valid on the next clock.
  - That window has centre out_row = R-(K-1)/2, out_col = C-(K-1)/2.
  - Latency is 1 clock from accept to out_valid.
  - Windows never straddle lines, because C >= K-1 masks stale columns.
- out_eof: asserted with the window whose source pixel is (HEIGHT-1, WIDTH-1).
- Frame window count: (WIDTH-K+1)*(HEIGHT-K+1).
- Throughput: one window per clock with out_ready held high.

Optional Feature:
- Macro: WINDOW_GEN_ERR_EN.
- When defined:
  - Adds output err_sticky (1 bit, reset 0).
  - Sets on in_sof accepted while in FILL or STREAM (short frame).
  - Sets on an accepted pixel without sof in DONE (long frame).
  - Cleared only by rst.
- When undefined: port absent; the same events are silently handled as above.

Decomposition:
- Package window_gen_pkg:
  - state enum {IDLE, FILL, STREAM, DONE};
  - function win_idx(r, c, K) returning the bit offset;
  - localparams for the centre offset (K-1)/2 and counter widths.
- Sub-module wingen_line_buffer: K-1 lines x WIDTH x DATA_WIDTH circular buffer. Ports: write enable, column address, write data, K-1 read column outputs. Read-before-write at the same address.

Test Plan:
All cases use WIDTH=8, HEIGHT=6, DATA_WIDTH=8, pixel = row*16+col.
- K=3, out_ready=1, sof on first pixel:
  - 24 windows emitted.
  - First window centre (1,1) with p(0,0)=0x00, p(1,1)=0x11, p(2,2)=0x22, one clock after accepting 0x22.
  - out_eof on the window with centre (4,6), holding (2,2)=0x57.
- K=3, out_ready random 50%:
  - Identical 24-window sequence; no drops or duplicates.
  - out_win/out_row/out_col stable while stalled; in_ready=0 exactly when out_valid && !out_ready.
- K=5:
  - 8 windows; first centre (2,2), element (0,0)=0x00, (4,4)=0x44.
  - Last window centre (3,5), element (4,4)=0x57, with out_eof.
- Restart: sof re-asserted after 20 pixels:
  - Counters restart at (0,0); no window is emitted for the new frame before 0x22.
  - err_sticky=1 when WINDOW_GEN_ERR_EN is defined.
- rst pulsed mid-STREAM:
  - out_valid=0 next edge.
  - Pixels without sof are dropped, producing no windows.
  - A new sof frame yields the normal 24 windows.
- After eof, 5 extra pixels without sof:
  - No output, in_ready stays 1.
  - err_sticky=1 with WINDOW_GEN_ERR_EN defined.

Source files
------------

// File: rtl/window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : window_gen_pkg
// Purpose : Shared state encoding and indexing helpers for window_gen_nxn.
// Revision: 1.0
// ============================================================================
package window_gen_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int KERNEL_MIN = 3;
   localparam int KERNEL_MAX = 7;

   function automatic int centre_off(input int k);
      return (k - 1) / 2;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit offset of window element (r,c); r=0 oldest row, c=0 leftmost column
   function automatic int win_idx(input int r, input int c, input int k, input int dw);
      return ((r * k) + c) * dw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wingen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module  : wingen_line_buffer
// Purpose : LINES x WIDTH column-addressed line store; read-before-write.
// Revision: 1.0
// ============================================================================
module wingen_line_buffer
   import window_gen_pkg::*;
#(
   parameter int WIDTH      = 640,
   parameter int DATA_WIDTH = 26,
   parameter int LINES      = 2,
   parameter int ADDR_WIDTH = cnt_w(WIDTH)
) (
   input  logic                        clk,
   input  logic                        wr_en,
   input  logic [ADDR_WIDTH-1:0]       col,
   input  logic [DATA_WIDTH-1:0]       wr_data,
   output logic [LINES*DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [LINES][WIDTH];

   generate
      for (genvar l = 0; l < LINES; l++) begin : g_rd
         assign rd_data[l*DATA_WIDTH +: DATA_WIDTH] = r_mem[l][col];
      end
   endgenerate

   // Each column shifts up one line; the newest pixel lands in the last line
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int l = 0; l < LINES - 1; l++) begin
            r_mem[l][col] <= r_mem[l+1][col];
         end
         r_mem[LINES-1][col] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/window_gen_nxn.sv
`default_nettype none
// ============================================================================
// Module  : window_gen_nxn
// Purpose : Streaming KxK interior-window generator with valid/ready framing.
//           Optional err_sticky output when WINDOW_GEN_ERR_EN is defined.
// Revision: 1.0
// ============================================================================
module window_gen_nxn
   import window_gen_pkg::*;
#(
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 512,
   parameter int DATA_WIDTH  = 26,
   parameter int KERNEL_SIZE = 3
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic                                          in_sof,
   input  logic [DATA_WIDTH-1:0]                         in_data,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] out_win,
   output logic [$clog2(HEIGHT)-1:0]                     out_row,
   output logic [$clog2(WIDTH)-1:0]                      out_col,
   output logic                                          out_eof
`ifdef WINDOW_GEN_ERR_EN
   ,
   output logic                                          err_sticky
`endif
);

   localparam int K   = KERNEL_SIZE;
   localparam int CW  = $clog2(WIDTH);
   localparam int RW  = $clog2(HEIGHT);
   localparam int OFF = centre_off(KERNEL_SIZE);
   localparam int WW  = K * K * DATA_WIDTH;

   localparam logic [CW-1:0] c_col_last     = CW'(WIDTH - 1);
   localparam logic [RW-1:0] c_row_last     = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] c_col_k        = CW'(K - 1);
   localparam logic [RW-1:0] c_row_k        = RW'(K - 1);
   localparam logic [RW-1:0] c_row_fill_end = RW'(K - 2);
   localparam logic [CW-1:0] c_col_off      = CW'(OFF);
   localparam logic [RW-1:0] c_row_off      = RW'(OFF);

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [CW-1:0]             r_col;
   logic [RW-1:0]             r_row;
   logic [WW-1:0]             r_win;
   logic [WW-1:0]             w_win_nxt;
   logic [(K-1)*DATA_WIDTH-1:0] w_lb_rd;
   logic [K*DATA_WIDTH-1:0]   w_col_vec;

   logic                      r_out_valid;
   logic [WW-1:0]             r_out_win;
   logic [RW-1:0]             r_out_row;
   logic [CW-1:0]             r_out_col;
   logic                      r_out_eof;

   logic                      w_accept;
   logic                      w_in_frame;
   logic                      w_take;
   logic [CW-1:0]             w_pos_col;
   logic [RW-1:0]             w_pos_row;
   logic                      w_eol;
   logic                      w_last;
   logic                      w_emit;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_in_frame = (r_state == FILL) || (r_state == STREAM);

   // An sof pixel is always (0,0) regardless of where the counters were
   assign w_take    = w_accept && (in_sof || w_in_frame);
   assign w_pos_col = in_sof ? '0 : r_col;
   assign w_pos_row = in_sof ? '0 : r_row;
   assign w_eol     = (w_pos_col == c_col_last);
   assign w_last    = w_eol && (w_pos_row == c_row_last);
   assign w_emit    = w_take && (w_pos_row >= c_row_k) && (w_pos_col >= c_col_k);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         if (in_sof) begin
            w_state_nxt = FILL;
         end else begin
            case (r_state)
               FILL:    if (w_eol && (w_pos_row == c_row_fill_end)) w_state_nxt = STREAM;
               STREAM:  if (w_last) w_state_nxt = DONE;
               default: w_state_nxt = r_state;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_take) begin
         if (w_eol) begin
            r_col <= '0;
            r_row <= w_last ? w_pos_row : w_pos_row + 1'b1;
         end else begin
            r_col <= w_pos_col + 1'b1;
            r_row <= w_pos_row;
         end
      end
   end

   wingen_line_buffer #(
      .WIDTH      (WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .LINES      (K - 1),
      .ADDR_WIDTH (CW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (w_take),
      .col     (w_pos_col),
      .wr_data (in_data),
      .rd_data (w_lb_rd)
   );

   // Row K-1 of the incoming column is the live pixel
   assign w_col_vec = {in_data, w_lb_rd};

   always_comb begin
      w_win_nxt = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            w_win_nxt[win_idx(r, c, K, DATA_WIDTH) +: DATA_WIDTH] =
               r_win[win_idx(r, c + 1, K, DATA_WIDTH) +: DATA_WIDTH];
         end
         w_win_nxt[win_idx(r, K - 1, K, DATA_WIDTH) +: DATA_WIDTH] =
            w_col_vec[r*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win <= '0;
      end else if (w_take) begin
         r_win <= w_win_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_win   <= '0;
         r_out_row   <= '0;
         r_out_col   <= '0;
         r_out_eof   <= 1'b0;
      end else if (in_ready) begin
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_out_win <= w_win_nxt;
            r_out_row <= w_pos_row - c_row_off;
            r_out_col <= w_pos_col - c_col_off;
            r_out_eof <= w_last;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_win   = r_out_win;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;
   assign out_eof   = r_out_eof;

`ifdef WINDOW_GEN_ERR_EN
   logic r_err;

   // Short frame: sof mid-frame.  Long frame: extra pixels after the last one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_accept && ((in_sof && w_in_frame) || (!in_sof && (r_state == DONE)))) begin
         r_err <= 1'b1;
      end
   end

   assign err_sticky = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_window_gen_nxn.sv
`default_nettype none
// ============================================================================
// Module  : tb_window_gen_nxn
// Purpose : Self-checking bench for window_gen_nxn (K=3 and K=5 instances).
// Revision: 1.0
// ============================================================================
module tb_window_gen_nxn;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          v3, s3, ir3, ov3, or3, eof3;
   logic [DW-1:0] d3;
   logic [71:0]   win3;
   logic [2:0]    row3, col3;
   logic          v5, s5, ir5, ov5, or5, eof5;
   logic [DW-1:0] d5;
   logic [199:0]  win5;
   logic [2:0]    row5, col5;
`ifdef WINDOW_GEN_ERR_EN
   logic          err3, err5;
`endif

   window_gen_nxn #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .KERNEL_SIZE(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .in_sof(s3), .in_data(d3),
      .out_valid(ov3), .out_ready(or3), .out_win(win3), .out_row(row3), .out_col(col3),
      .out_eof(eof3)
`ifdef WINDOW_GEN_ERR_EN
      , .err_sticky(err3)
`endif
   );

   window_gen_nxn #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW), .KERNEL_SIZE(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(v5), .in_ready(ir5), .in_sof(s5), .in_data(d5),
      .out_valid(ov5), .out_ready(or5), .out_win(win5), .out_row(row5), .out_col(col5),
      .out_eof(eof5)
`ifdef WINDOW_GEN_ERR_EN
      , .err_sticky(err5)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: raw image array plus frame position, windows cut straight from it
   typedef struct {
      logic [255:0] win;
      int           row;
      int           col;
      bit           eof;
   } exp_t;

   exp_t          q3[$];
   exp_t          q5[$];
   logic [7:0]    img [2][H][W];
   int            m_row[2], m_col[2];
   bit            m_act[2], m_done[2], m_err[2];

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_row[u] = 0; m_col[u] = 0; m_act[u] = 0; m_done[u] = 0; m_err[u] = 0;
      end
      q3.delete();
      q5.delete();
   endtask

   task automatic model_pixel(input int u, input logic [7:0] d, input bit sof);
      int   k;
      exp_t e;
      k = (u == 0) ? 3 : 5;
      if (sof) begin
         if (m_act[u]) m_err[u] = 1;
         m_act[u] = 1; m_done[u] = 0; m_row[u] = 0; m_col[u] = 0;
      end else if (!m_act[u]) begin
         if (m_done[u]) m_err[u] = 1;
         return;
      end
      img[u][m_row[u]][m_col[u]] = d;
      if (m_row[u] >= k - 1 && m_col[u] >= k - 1) begin
         e.win = '0;
         for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
               e.win[((r*k)+c)*8 +: 8] = img[u][m_row[u]-k+1+r][m_col[u]-k+1+c];
         e.row = m_row[u] - (k - 1) / 2;
         e.col = m_col[u] - (k - 1) / 2;
         e.eof = (m_row[u] == H - 1) && (m_col[u] == W - 1);
         if (u == 0) q3.push_back(e); else q5.push_back(e);
      end
      if (m_row[u] == H - 1 && m_col[u] == W - 1) begin
         m_act[u] = 0; m_done[u] = 1;
      end else if (m_col[u] == W - 1) begin
         m_col[u] = 0; m_row[u]++;
      end else begin
         m_col[u]++;
      end
   endtask

   task automatic push(input int u, input logic [7:0] d, input bit sof);
      int t = 0;
      if (u == 0) begin v3 = 1'b1; d3 = d; s3 = sof; end
      else        begin v5 = 1'b1; d5 = d; s5 = sof; end
      @(negedge clk);
      while ((((u == 0) ? ir3 : ir5) !== 1'b1) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check_eq("accept_timeout", t, 0);
      @(posedge clk);
      #1;
      model_pixel(u, d, sof);
      if (u == 0) begin v3 = 1'b0; s3 = 1'b0; end
      else        begin v5 = 1'b0; s5 = 1'b0; end
   endtask

   task automatic send_frame(input int u);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            push(u, 8'(r*16 + c), (r == 0) && (c == 0));
   endtask

   task automatic drain(input int u);
      int t = 0;
      while (((u == 0) ? q3.size() : q5.size()) != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) check_eq("drain_timeout", t, 0);
      repeat (3) @(negedge clk);
   endtask

   // Output monitors
   int           n_win3 = 0, n_win5 = 0;
   bit           h_stall3 = 0;
   logic [71:0]  h_win3;
   logic [2:0]   h_row3, h_col3;
   logic         h_eof3;
   logic [2:0]   eof_row3, eof_col3;
   logic [7:0]   eof_p22;
   logic [2:0]   first_row5, first_col5, eof_row5, eof_col5;
   logic [7:0]   first_p00_5, first_p44_5, eof_p44_5;
   exp_t         e3, e5;

   always @(negedge clk) begin
      if (!rst) begin
         check_eq("in_ready3", ir3, !(ov3 && !or3));
         if (h_stall3) begin
            check_eq("stall_valid3", ov3, 1'b1);
            check_eq("stall_win3", win3, h_win3);
            check_eq("stall_row3", row3, h_row3);
            check_eq("stall_col3", col3, h_col3);
            check_eq("stall_eof3", eof3, h_eof3);
         end
         if (ov3 && or3) begin
            check_eq("win3_expected", q3.size() != 0, 1'b1);
            if (q3.size() != 0) begin
               e3 = q3.pop_front();
               check_eq("win3", win3, e3.win);
               check_eq("row3", row3, e3.row);
               check_eq("col3", col3, e3.col);
               check_eq("eof3", eof3, e3.eof);
            end
            if (eof3) begin
               eof_row3 = row3; eof_col3 = col3; eof_p22 = win3[64 +: 8];
            end
            n_win3++;
         end
         h_stall3 = ov3 && !or3;
         h_win3 = win3; h_row3 = row3; h_col3 = col3; h_eof3 = eof3;
      end else begin
         h_stall3 = 0;
      end
   end

   always @(negedge clk) begin
      if (!rst && ov5 && or5) begin
         check_eq("win5_expected", q5.size() != 0, 1'b1);
         if (q5.size() != 0) begin
            e5 = q5.pop_front();
            check_eq("win5", win5, e5.win);
            check_eq("row5", row5, e5.row);
            check_eq("col5", col5, e5.col);
            check_eq("eof5", eof5, e5.eof);
         end
         if (n_win5 == 0) begin
            first_row5 = row5; first_col5 = col5;
            first_p00_5 = win5[0 +: 8]; first_p44_5 = win5[24*8 +: 8];
         end
         if (eof5) begin
            eof_row5 = row5; eof_col5 = col5; eof_p44_5 = win5[24*8 +: 8];
         end
         n_win5++;
      end
   end

   bit rnd3 = 0;
   initial begin
      or3 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         or3 = rnd3 ? 1'($urandom % 2) : 1'b1;
      end
   end

   int n_before;

   initial begin
      rst = 1'b1;
      v3 = 0; s3 = 0; d3 = '0;
      v5 = 0; s5 = 0; d5 = '0; or5 = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_valid3", ov3, 1'b0);
      check_eq("rst_eof3", eof3, 1'b0);
      check_eq("rst_win3", win3, '0);
      check_eq("rst_row3", row3, '0);
      check_eq("rst_col3", col3, '0);
      check_eq("rst_ready3", ir3, 1'b1);
      check_eq("rst_valid5", ov5, 1'b0);
      check_eq("rst_win5", win5, '0);
`ifdef WINDOW_GEN_ERR_EN
      check_eq("rst_err3", err3, 1'b0);
`endif
      @(posedge clk);
      #1 rst = 1'b0;

      // K=3 full frame, out_ready high
      n_win3 = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            push(0, 8'(r*16 + c), (r == 0) && (c == 0));
            if (r == 2 && c == 2) begin
               check_eq("first_valid", ov3, 1'b1);
               check_eq("first_row", row3, 3'd1);
               check_eq("first_col", col3, 3'd1);
               check_eq("first_p00", win3[0 +: 8], 8'h00);
               check_eq("first_p11", win3[4*8 +: 8], 8'h11);
               check_eq("first_p22", win3[8*8 +: 8], 8'h22);
            end
         end
      end
      drain(0);
      check_eq("frame1_count", n_win3, 24);
      check_eq("eof_row", eof_row3, 3'd4);
      check_eq("eof_col", eof_col3, 3'd6);
      check_eq("eof_p22", eof_p22, 8'h57);

      // Long frame: extra pixels after eof are dropped
      n_before = n_win3;
      for (int i = 0; i < 5; i++) begin
         push(0, 8'(8'hA0 + i), 1'b0);
         check_eq("extra_ready", ir3, 1'b1);
      end
      drain(0);
      check_eq("extra_count", n_win3, n_before);
`ifdef WINDOW_GEN_ERR_EN
      check_eq("err_long", err3, m_err[0]);
`endif

      // K=3 frame with random backpressure
      n_win3 = 0;
      rnd3 = 1;
      send_frame(0);
      drain(0);
      rnd3 = 0;
      repeat (3) @(negedge clk);
      check_eq("frame_rnd_count", n_win3, 24);

      // K=5 frame
      n_win5 = 0;
      send_frame(1);
      drain(1);
      check_eq("k5_count", n_win5, 8);
      check_eq("k5_first_row", first_row5, 3'd2);
      check_eq("k5_first_col", first_col5, 3'd2);
      check_eq("k5_first_p00", first_p00_5, 8'h00);
      check_eq("k5_first_p44", first_p44_5, 8'h44);
      check_eq("k5_eof_row", eof_row5, 3'd3);
      check_eq("k5_eof_col", eof_col5, 3'd5);
      check_eq("k5_eof_p44", eof_p44_5, 8'h57);

      // Reset mid-STREAM
      for (int i = 0; i < 30; i++) push(0, 8'((i / W) * 16 + (i % W)), i == 0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_valid", ov3, 1'b0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      n_before = n_win3;
      for (int i = 0; i < 10; i++) push(0, 8'(8'h30 + i), 1'b0);
      drain(0);
      check_eq("post_rst_dropped", n_win3, n_before);
`ifdef WINDOW_GEN_ERR_EN
      check_eq("post_rst_err", err3, 1'b0);
`endif
      send_frame(0);
      drain(0);
      check_eq("post_rst_count", n_win3 - n_before, 24);

      // Short frame: sof again after 20 pixels
      n_before = n_win3;
      for (int i = 0; i < 20; i++) push(0, 8'((i / W) * 16 + (i % W)), i == 0);
      send_frame(0);
      drain(0);
      check_eq("restart_count", n_win3 - n_before, 26);
`ifdef WINDOW_GEN_ERR_EN
      check_eq("err_short", err3, m_err[0]);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed timeout expected completion");
      $fatal(1, "global timeout");
   end

endmodule
`default_nettype wire
